bch_ecc_ctrl: RTL and testbench



---
 rtl/bch_ecc_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_bch_ecc_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_ecc_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bch_ecc_ctrl
//
// Sequences an external combinational BCH encoder/decoder pair around a
// single-port word memory. Host requests are handled one at a time:
//   write : parity from the encoder is appended and {parity, data} is stored.
//   read  : the stored word is decoded; correctable errors are fixed with the
//           decoder mask (and optionally scrubbed back), uncorrectable words
//           are returned raw. Saturating counters track both outcomes.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid_i / req_ready_o host request handshake (ready only when idle)
//   req_we_i, req_addr_i,
//   req_wdata_i               request type, address, write data
//   rsp_valid_o / rsp_ready_i response handshake
//   rsp_rdata_o, rsp_err_o    read data (0 for writes), 00/01/10 status
//   mem_en_o, mem_we_o,
//   mem_addr_o, mem_wdata_o   memory strobe, write enable, address, {p, d}
//   mem_rdata_i               read word, valid the cycle after the strobe
//   enc_d_o / enc_p_i         encoder data in / parity out
//   dec_d_o, dec_ecc_o        decoder data and parity in
//   dec_msk_i, dec_err_i      decoder correction mask and status
//   corr_cnt_o, uncorr_cnt_o  saturating corrected / uncorrectable counts
// -----------------------------------------------------------------------------
module bch_ecc_ctrl #(
    parameter int D_WIDTH   = 48,
    parameter int P_WIDTH   = 12,
    parameter int A_WIDTH   = 10,
    parameter int CNT_WIDTH = 16,
    parameter bit SCRUB_EN  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_we_i,
    input  logic [A_WIDTH-1:0]         req_addr_i,
    input  logic [D_WIDTH-1:0]         req_wdata_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [D_WIDTH-1:0]         rsp_rdata_o,
    output logic [1:0]                 rsp_err_o,
    output logic                       mem_en_o,
    output logic                       mem_we_o,
    output logic [A_WIDTH-1:0]         mem_addr_o,
    output logic [P_WIDTH+D_WIDTH-1:0] mem_wdata_o,
    input  logic [P_WIDTH+D_WIDTH-1:0] mem_rdata_i,
    output logic [D_WIDTH-1:0]         enc_d_o,
    input  logic [P_WIDTH-1:0]         enc_p_i,
    output logic [D_WIDTH-1:0]         dec_d_o,
    output logic [P_WIDTH-1:0]         dec_ecc_o,
    input  logic [D_WIDTH-1:0]         dec_msk_i,
    input  logic [1:0]                 dec_err_i,
    output logic [CNT_WIDTH-1:0]       corr_cnt_o,
    output logic [CNT_WIDTH-1:0]       uncorr_cnt_o
);

    typedef enum logic [2:0] {
        IDLE, WR, RD, RD_WAIT, DEC, SCRUB, RSP
    } state_t;

    localparam logic [1:0] ERR_CLEAN  = 2'b00;
    localparam logic [1:0] ERR_CORR   = 2'b01;
    localparam logic [1:0] ERR_UNCORR = 2'b10;

    state_t               state, state_nxt;
    logic [D_WIDTH-1:0]   dreg;
    logic [P_WIDTH-1:0]   preg;
    logic [A_WIDTH-1:0]   areg;
    logic                 wereg;
    logic [1:0]           errreg;

    // Uncorrectable wins over "detected", so status 11 is treated as 10.
    logic uncorr_hit, corr_hit;
    assign uncorr_hit = dec_err_i[1];
    assign corr_hit   = dec_err_i[0] & ~dec_err_i[1];

    // The codec works on the held word; in SCRUB dreg already holds the
    // corrected data, so enc_p_i is the fresh parity for the write-back.
    assign enc_d_o   = dreg;
    assign dec_d_o   = dreg;
    assign dec_ecc_o = preg;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output and next-state gets a default first so no path
        // through the case leaves a value unassigned (no latches).
        state_nxt   = state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_rdata_o = '0;
        rsp_err_o   = ERR_CLEAN;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_nxt = req_we_i ? WR : RD;
                end
            end
            WR: begin
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = areg;
                mem_wdata_o = {enc_p_i, dreg};
                state_nxt   = RSP;
            end
            RD: begin
                mem_en_o   = 1'b1;
                mem_addr_o = areg;
                state_nxt  = RD_WAIT;
            end
            RD_WAIT: begin
                state_nxt = DEC;
            end
            DEC: begin
                state_nxt = (corr_hit && SCRUB_EN) ? SCRUB : RSP;
            end
            SCRUB: begin
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = areg;
                mem_wdata_o = {enc_p_i, dreg};
                state_nxt   = RSP;
            end
            RSP: begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = errreg;
                rsp_rdata_o = wereg ? '0 : dreg;
                if (rsp_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers; they only change in the states that own them, so
    // the response outputs hold steady for as long as the host stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dreg         <= '0;
            preg         <= '0;
            areg         <= '0;
            wereg        <= 1'b0;
            errreg       <= ERR_CLEAN;
            corr_cnt_o   <= '0;
            uncorr_cnt_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        areg  <= req_addr_i;
                        wereg <= req_we_i;
                        dreg  <= req_wdata_i;
                    end
                end
                WR: begin
                    errreg <= ERR_CLEAN;
                end
                RD_WAIT: begin
                    {preg, dreg} <= mem_rdata_i;
                end
                DEC: begin
                    if (uncorr_hit) begin
                        errreg <= ERR_UNCORR;
                        if (uncorr_cnt_o != '1) begin
                            uncorr_cnt_o <= uncorr_cnt_o + CNT_WIDTH'(1);
                        end
                    end else if (corr_hit) begin
                        errreg <= ERR_CORR;
                        dreg   <= dreg ^ dec_msk_i;
                        if (corr_cnt_o != '1) begin
                            corr_cnt_o <= corr_cnt_o + CNT_WIDTH'(1);
                        end
                    end else begin
                        errreg <= ERR_CLEAN;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bch_ecc_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_bch_ecc_ctrl
//
// Self-checking bench for bch_ecc_ctrl. Provides a linear single-error-
// correcting code as the stand-in encoder/decoder, a single-port memory
// model, and a scoreboard of expected responses. Runs a vector table, then
// hand-written back-pressure, counter-saturation and reset-abort sequences.
// -----------------------------------------------------------------------------
module tb_bch_ecc_ctrl;

    localparam int DW = 48;
    localparam int PW = 12;
    localparam int AW = 10;
    localparam int CW = 4;
    localparam int MW = DW + PW;
    localparam int NV = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_we_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic [DW-1:0] req_wdata_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b1;
    logic [DW-1:0] rsp_rdata_o;
    logic [1:0]    rsp_err_o;
    logic          mem_en_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [MW-1:0] mem_wdata_o;
    logic [MW-1:0] mem_rdata_i = '0;
    logic [DW-1:0] enc_d_o;
    logic [PW-1:0] enc_p_i;
    logic [DW-1:0] dec_d_o;
    logic [PW-1:0] dec_ecc_o;
    logic [DW-1:0] dec_msk_i;
    logic [1:0]    dec_err_i;
    logic [CW-1:0] corr_cnt_o;
    logic [CW-1:0] uncorr_cnt_o;

    bch_ecc_ctrl #(
        .D_WIDTH(DW), .P_WIDTH(PW), .A_WIDTH(AW), .CNT_WIDTH(CW), .SCRUB_EN(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .enc_d_o(enc_d_o), .enc_p_i(enc_p_i),
        .dec_d_o(dec_d_o), .dec_ecc_o(dec_ecc_o),
        .dec_msk_i(dec_msk_i), .dec_err_i(dec_err_i),
        .corr_cnt_o(corr_cnt_o), .uncorr_cnt_o(uncorr_cnt_o)
    );

    always #5 clk = ~clk;

    // ---------------- codec model (linear, distinct syndrome per data bit)
    function automatic logic [PW-1:0] enc_f(input logic [DW-1:0] d);
        logic [PW-1:0] p;
        p = '0;
        for (int i = 0; i < DW; i++) begin
            if (d[i]) p[5:0] = p[5:0] ^ 6'(i + 1);
        end
        p[6]  = ^d;
        p[7]  = ^d[47:24];
        p[8]  = ^d[23:0];
        p[9]  = ^d[15:0];
        p[10] = ^d[31:16];
        p[11] = ^d[47:32];
        return p;
    endfunction

    assign enc_p_i = enc_f(enc_d_o);

    logic [PW-1:0] syn;
    logic [DW-1:0] unit;
    always_comb begin
        syn       = enc_f(dec_d_o) ^ dec_ecc_o;
        unit      = '0;
        dec_msk_i = '0;
        dec_err_i = 2'b00;
        if (syn != '0) begin
            dec_err_i = syn[6] ? 2'b11 : 2'b10;
            for (int i = 0; i < DW; i++) begin
                unit    = '0;
                unit[i] = 1'b1;
                if (enc_f(unit) == syn) begin
                    dec_msk_i = unit;
                    dec_err_i = 2'b01;
                end
            end
        end
    end

    // ---------------- memory model, cycle counter, write-strobe counter
    logic [MW-1:0] mem [0:(1<<AW)-1];
    logic          flip_req = 1'b0;
    logic [AW-1:0] flip_addr = '0;
    logic [DW-1:0] flip_mask = '0;
    int            cyc = 0;
    int            wr_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en_o && mem_we_o) begin
            mem[mem_addr_o] <= mem_wdata_o;
            wr_cnt          <= wr_cnt + 1;
        end
        if (mem_en_o && !mem_we_o) mem_rdata_i <= mem[mem_addr_o];
        if (flip_req) mem[flip_addr] <= mem[flip_addr] ^ {{PW{1'b0}}, flip_mask};
    end

    // ---------------- checking
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [DW-1:0] rdata;
        logic [1:0]    err;
        int            lat;
        int            wr;
        int            req_cyc;
        int            req_wr;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   first_cyc = 0;
    bit   in_rsp = 1'b0;

    always @(negedge clk) begin
        if (!rst && rsp_valid_o) begin
            if (!in_rsp) begin
                in_rsp    = 1'b1;
                first_cyc = cyc;
            end
            if (rsp_ready_i) begin
                in_rsp = 1'b0;
                check("rsp_expected", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rsp_rdata", 64'(rsp_rdata_o), 64'(e.rdata));
                    check("rsp_err", 64'(rsp_err_o), 64'(e.err));
                    check("rsp_latency", 64'(first_cyc - e.req_cyc), 64'(e.lat));
                    check("mem_writes", 64'(wr_cnt - e.req_wr), 64'(e.wr));
                end
            end
        end
    end

    // ---------------- drivers (called at posedge + 1)
    task automatic wait_ready();
        int t = 0;
        while (!req_ready_o && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("req_ready_wait", 64'(req_ready_o), 64'(1));
    endtask

    task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [DW-1:0] er, input logic [1:0] ee, input int lat, input int wr);
        exp_t x;
        wait_ready();
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wd;
        x.rdata = er; x.err = ee; x.lat = lat; x.wr = wr;
        x.req_cyc = cyc; x.req_wr = wr_cnt;
        sb.push_back(x);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        req_wdata_i = '0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("sb_drained", 64'(sb.size()), 64'(0));
    endtask

    task automatic flip(input logic [AW-1:0] addr, input logic [DW-1:0] mask);
        flip_addr = addr;
        flip_mask = mask;
        flip_req  = 1'b1;
        @(posedge clk); #1;
        flip_req  = 1'b0;
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] flip;
        logic [DW-1:0] exp_rdata;
        logic [1:0]    exp_err;
        int            lat;
        int            wr;
    } vec_t;

    vec_t vt[NV];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [DW-1:0] m;
        logic [CW-1:0] exp_c;
        logic          stable;
        logic          activity;
        int            t;

        vt[0]  = '{1'b1, 10'd5,    48'h0000_1234_5678, 48'h0,              48'h0,              2'b00, 2, 1};
        vt[1]  = '{1'b0, 10'd5,    48'h0,              48'h0,              48'h0000_1234_5678, 2'b00, 4, 0};
        vt[2]  = '{1'b0, 10'd5,    48'h0,              48'h0000_0000_0080, 48'h0000_1234_5678, 2'b01, 5, 1};
        vt[3]  = '{1'b0, 10'd5,    48'h0,              48'h0,              48'h0000_1234_5678, 2'b00, 4, 0};
        vt[4]  = '{1'b0, 10'd5,    48'h0,              48'h0000_0000_0007, 48'h0000_1234_567F, 2'b10, 4, 0};
        vt[5]  = '{1'b1, 10'd1023, 48'hFFFF_FFFF_FFFF, 48'h0,              48'h0,              2'b00, 2, 1};
        vt[6]  = '{1'b0, 10'd1023, 48'h0,              48'h8000_0000_0000, 48'hFFFF_FFFF_FFFF, 2'b01, 5, 1};
        vt[7]  = '{1'b0, 10'd1023, 48'h0,              48'h0,              48'hFFFF_FFFF_FFFF, 2'b00, 4, 0};
        vt[8]  = '{1'b1, 10'd300,  48'h0123_4567_89AB, 48'h0,              48'h0,              2'b00, 2, 1};
        vt[9]  = '{1'b0, 10'd300,  48'h0,              48'h0100_0000_0400, 48'h0023_4567_8DAB, 2'b10, 4, 0};
        vt[10] = '{1'b1, 10'd0,    48'h0,              48'h0,              48'h0,              2'b00, 2, 1};
        vt[11] = '{1'b0, 10'd0,    48'h0,              48'h0,              48'h0,              2'b00, 4, 0};

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        check("rst_req_ready", 64'(req_ready_o), 64'(1));
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
        check("rst_mem_en", 64'(mem_en_o), 64'(0));
        check("rst_mem_we", 64'(mem_we_o), 64'(0));
        check("rst_mem_addr", 64'(mem_addr_o), 64'(0));
        check("rst_rsp_rdata", 64'(rsp_rdata_o), 64'(0));
        check("rst_enc_d", 64'(enc_d_o), 64'(0));
        check("rst_corr_cnt", 64'(corr_cnt_o), 64'(0));
        check("rst_uncorr_cnt", 64'(uncorr_cnt_o), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Vector table
        for (int k = 0; k < NV; k++) begin
            if (vt[k].flip != '0) flip(vt[k].addr, vt[k].flip);
            send(vt[k].we, vt[k].addr, vt[k].wdata, vt[k].exp_rdata, vt[k].exp_err,
                 vt[k].lat, vt[k].wr);
            wait_done();
        end
        check("corr_cnt_table", 64'(corr_cnt_o), 64'(2));
        check("uncorr_cnt_table", 64'(uncorr_cnt_o), 64'(2));

        // Host back-pressure: response held for 10 cycles
        rsp_ready_i = 1'b0;
        send(1'b0, 10'd1023, '0, 48'hFFFF_FFFF_FFFF, 2'b00, 4, 0);
        t = 0;
        while (!rsp_valid_o && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("stall_rsp_seen", 64'(rsp_valid_o), 64'(1));
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            stable = rsp_valid_o && (rsp_rdata_o == 48'hFFFF_FFFF_FFFF) &&
                     (rsp_err_o == 2'b00) && !req_ready_o && !mem_en_o;
            check("stall_hold", 64'(stable), 64'(1));
        end
        rsp_ready_i = 1'b1;
        wait_done();
        check("stall_release_idle", 64'(req_ready_o), 64'(1));

        // Counter saturation with 4-bit counters
        send(1'b1, 10'd200, 48'h0000_ABCD_0000, '0, 2'b00, 2, 1);
        wait_done();
        exp_c = 4'd2;
        for (int k = 0; k < 20; k++) begin
            m = '0;
            m[(k * 5) % DW] = 1'b1;
            flip(10'd200, m);
            send(1'b0, 10'd200, '0, 48'h0000_ABCD_0000, 2'b01, 5, 1);
            wait_done();
            exp_c = (exp_c == 4'hF) ? 4'hF : exp_c + 4'd1;
            check("corr_cnt_sat", 64'(corr_cnt_o), 64'(exp_c));
        end
        check("uncorr_cnt_after_sat", 64'(uncorr_cnt_o), 64'(2));

        // Reset during RD_WAIT aborts the read
        wait_ready();
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = 10'd200;
        @(posedge clk); #1;            // handshake done, now in RD
        req_valid_i = 1'b0;
        @(posedge clk); #1;            // now in RD_WAIT
        rst = 1'b1;
        #1;
        check("abort_mem_en", 64'(mem_en_o), 64'(0));
        check("abort_rsp_valid", 64'(rsp_valid_o), 64'(0));
        check("abort_corr_cnt", 64'(corr_cnt_o), 64'(0));
        check("abort_uncorr_cnt", 64'(uncorr_cnt_o), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_req_ready", 64'(req_ready_o), 64'(1));
        activity = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            activity = activity | rsp_valid_o | mem_en_o;
        end
        check("abort_no_activity", 64'(activity), 64'(0));

        // Normal operation resumes after the abort
        send(1'b0, 10'd200, '0, 48'h0000_ABCD_0000, 2'b00, 4, 0);
        wait_done();
        check("post_abort_corr_cnt", 64'(corr_cnt_o), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
